// File: rtl/strv32i_pkg.sv
// Shared STRV32I encodings: write-back source selects, load sizes and the write-back FSM states.
package strv32i_pkg;

    localparam logic [2:0] WB_ALU    = 3'b000;
    localparam logic [2:0] WB_LU     = 3'b001;
    localparam logic [2:0] WB_IMM    = 3'b010;
    localparam logic [2:0] WB_IADDER = 3'b011;
    localparam logic [2:0] WB_PC4    = 3'b101;

    localparam logic [1:0] LOAD_SIZE_BYTE   = 2'b00;
    localparam logic [1:0] LOAD_SIZE_HALF   = 2'b01;
    localparam logic [1:0] LOAD_SIZE_WORD   = 2'b10;
    localparam logic [1:0] LOAD_SIZE_DOUBLE = 2'b11;

    typedef enum logic [0:0] {
        S_RUN,
        S_WAIT_LOAD
    } wb_state_e;

endpackage

// File: rtl/load_align_unit.sv
// Combinational load aligner: shifts the naturally aligned memory word down by the byte offset,
// sign- or zero-extends the selected width and flags misaligned accesses.
module load_align_unit
    import strv32i_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] data_in,
    input  logic [2:0]      offset_in,
    input  logic [1:0]      size_in,
    input  logic            unsigned_in,
    output logic [XLEN-1:0] data_out,
    output logic            misaligned_out
);

    localparam int unsigned OFF_W = (XLEN == 64) ? 3 : 2;

    logic [OFF_W-1:0] off;
    logic [1:0]       size_eff;
    logic [XLEN-1:0]  shifted;
    logic             sign_bit;
    logic             fill;
    int               msb;

    assign off = offset_in[OFF_W-1:0];

    // A 32-bit datapath has no doubleword loads; treat them as words.
    assign size_eff = (XLEN == 32 && size_in == LOAD_SIZE_DOUBLE) ? LOAD_SIZE_WORD : size_in;

    assign shifted = data_in >> {off, 3'b000};

    always_comb begin
        msb            = XLEN - 1;
        sign_bit       = 1'b0;
        misaligned_out = 1'b0;
        unique case (size_eff)
            LOAD_SIZE_BYTE: begin
                msb      = 7;
                sign_bit = shifted[7];
            end
            LOAD_SIZE_HALF: begin
                msb            = 15;
                sign_bit       = shifted[15];
                misaligned_out = offset_in[0];
            end
            LOAD_SIZE_WORD: begin
                msb            = 31;
                sign_bit       = shifted[31];
                misaligned_out = |offset_in[1:0];
            end
            default: begin
                msb            = XLEN - 1;
                sign_bit       = shifted[XLEN-1];
                misaligned_out = |offset_in;
            end
        endcase
    end

    assign fill = !unsigned_in && sign_bit;

    always_comb begin
        data_out = '0;
        for (int i = 0; i < XLEN; i++) begin
            data_out[i] = (i <= msb) ? shifted[i] : fill;
        end
    end

endmodule

// File: rtl/wb_select_stage.sv
// Registered write-back stage: selects the result source, waits for load responses and drives
// the register-file write port one cycle after the result is known.
module wb_select_stage
    import strv32i_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              in_valid_in,
    output logic              in_ready_out,
    input  logic              flush_in,
    input  logic              alu_src_in,
    input  logic [2:0]        wb_sel_in,
    input  logic [XLEN-1:0]   alu_result_in,
    input  logic [XLEN-1:0]   imm_in,
    input  logic [XLEN-1:0]   iadder_in,
    input  logic [XLEN-1:0]   pc_plus_4_in,
    input  logic [XLEN-1:0]   rs2_in,
    input  logic [REG_AW-1:0] rd_addr_in,
    input  logic              rf_wr_en_in,
    input  logic [1:0]        load_size_in,
    input  logic              load_unsigned_in,
    input  logic [XLEN-1:0]   load_data_in,
    input  logic              load_valid_in,
    output logic [XLEN-1:0]   alu_2nd_src_out,
    output logic              rf_wr_en_out,
    output logic [REG_AW-1:0] rf_rd_addr_out,
    output logic [XLEN-1:0]   rf_wr_data_out,
    output logic              wb_valid_out,
    output logic              load_misaligned_out
);

    wb_state_e         state_q, state_d;
    logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
    logic              ld_wr_en_q, ld_wr_en_d;
    logic [1:0]        ld_size_q, ld_size_d;
    logic              ld_unsigned_q, ld_unsigned_d;
    logic [2:0]        ld_offset_q, ld_offset_d;

    logic              wr_en_q, wr_en_d;
    logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]   wr_data_q, wr_data_d;
    logic              wb_valid_q, wb_valid_d;
    logic              misaligned_q, misaligned_d;

    logic              accept;
    logic [XLEN-1:0]   src_data;
    logic [XLEN-1:0]   align_data;
    logic              align_misaligned;

    assign alu_2nd_src_out = alu_src_in ? rs2_in : imm_in;
    assign in_ready_out    = (state_q == S_RUN);
    assign accept          = in_valid_in && in_ready_out && !flush_in;

    // Unused encodings fall back to the ALU result.
    always_comb begin
        case (wb_sel_in)
            WB_IMM:    src_data = imm_in;
            WB_IADDER: src_data = iadder_in;
            WB_PC4:    src_data = pc_plus_4_in;
            default:   src_data = alu_result_in;
        endcase
    end

    load_align_unit #(
        .XLEN(XLEN)
    ) u_load_align (
        .data_in       (load_data_in),
        .offset_in     (ld_offset_q),
        .size_in       (ld_size_q),
        .unsigned_in   (ld_unsigned_q),
        .data_out      (align_data),
        .misaligned_out(align_misaligned)
    );

    always_comb begin
        state_d       = state_q;
        ld_rd_d       = ld_rd_q;
        ld_wr_en_d    = ld_wr_en_q;
        ld_size_d     = ld_size_q;
        ld_unsigned_d = ld_unsigned_q;
        ld_offset_d   = ld_offset_q;
        wr_en_d       = 1'b0;
        wb_valid_d    = 1'b0;
        misaligned_d  = 1'b0;
        rd_addr_d     = rd_addr_q;
        wr_data_d     = wr_data_q;

        unique case (state_q)
            S_RUN: begin
                if (accept) begin
                    if (wb_sel_in == WB_LU) begin
                        ld_rd_d       = rd_addr_in;
                        ld_wr_en_d    = rf_wr_en_in;
                        ld_size_d     = load_size_in;
                        ld_unsigned_d = load_unsigned_in;
                        ld_offset_d   = iadder_in[2:0];
                        state_d       = S_WAIT_LOAD;
                    end else begin
                        wb_valid_d = 1'b1;
                        wr_en_d    = rf_wr_en_in && (rd_addr_in != '0);
                        rd_addr_d  = rd_addr_in;
                        wr_data_d  = src_data;
                    end
                end
            end
            S_WAIT_LOAD: begin
                // A flush wins over a same-cycle response, which is dropped.
                if (flush_in) begin
                    state_d = S_RUN;
                end else if (load_valid_in) begin
                    state_d      = S_RUN;
                    wb_valid_d   = 1'b1;
                    misaligned_d = align_misaligned;
                    wr_en_d      = ld_wr_en_q && (ld_rd_q != '0) && !align_misaligned;
                    rd_addr_d    = ld_rd_q;
                    wr_data_d    = align_data;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= S_RUN;
            ld_rd_q       <= '0;
            ld_wr_en_q    <= 1'b0;
            ld_size_q     <= '0;
            ld_unsigned_q <= 1'b0;
            ld_offset_q   <= '0;
            wr_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            wr_data_q     <= '0;
            wb_valid_q    <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ld_rd_q       <= ld_rd_d;
            ld_wr_en_q    <= ld_wr_en_d;
            ld_size_q     <= ld_size_d;
            ld_unsigned_q <= ld_unsigned_d;
            ld_offset_q   <= ld_offset_d;
            wr_en_q       <= wr_en_d;
            rd_addr_q     <= rd_addr_d;
            wr_data_q     <= wr_data_d;
            wb_valid_q    <= wb_valid_d;
            misaligned_q  <= misaligned_d;
        end
    end

    assign rf_wr_en_out        = wr_en_q;
    assign rf_rd_addr_out      = rd_addr_q;
    assign rf_wr_data_out      = wr_data_q;
    assign wb_valid_out        = wb_valid_q;
    assign load_misaligned_out = misaligned_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed plus randomized bench for wb_select_stage (XLEN=32), checked against a byte-level
// reference model of loads and write-back source selection.
module tb_wb_select_stage;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic              alu_src;
    logic [2:0]        wb_sel;
    logic [XLEN-1:0]   alu_result, imm, iadder, pc_plus_4, rs2;
    logic [REG_AW-1:0] rd_addr;
    logic              rf_wr_en_i;
    logic [1:0]        load_size;
    logic              load_unsigned;
    logic [XLEN-1:0]   load_data;
    logic              load_valid;
    logic [XLEN-1:0]   alu_2nd_src;
    logic              rf_wr_en_o;
    logic [REG_AW-1:0] rf_rd_addr;
    logic [XLEN-1:0]   rf_wr_data;
    logic              wb_valid;
    logic              load_misaligned;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    wb_select_stage #(
        .XLEN  (XLEN),
        .REG_AW(REG_AW)
    ) dut (
        .clk_in             (clk),
        .rst_n_in           (rst_n),
        .in_valid_in        (in_valid),
        .in_ready_out       (in_ready),
        .flush_in           (flush),
        .alu_src_in         (alu_src),
        .wb_sel_in          (wb_sel),
        .alu_result_in      (alu_result),
        .imm_in             (imm),
        .iadder_in          (iadder),
        .pc_plus_4_in       (pc_plus_4),
        .rs2_in             (rs2),
        .rd_addr_in         (rd_addr),
        .rf_wr_en_in        (rf_wr_en_i),
        .load_size_in       (load_size),
        .load_unsigned_in   (load_unsigned),
        .load_data_in       (load_data),
        .load_valid_in      (load_valid),
        .alu_2nd_src_out    (alu_2nd_src),
        .rf_wr_en_out       (rf_wr_en_o),
        .rf_rd_addr_out     (rf_rd_addr),
        .rf_wr_data_out     (rf_wr_data),
        .wb_valid_out       (wb_valid),
        .load_misaligned_out(load_misaligned)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pulses(input string tag, input bit exp_valid, input bit exp_we,
                              input bit exp_mis);
        chk({tag, ".wb_valid"}, 64'(wb_valid), 64'(exp_valid));
        chk({tag, ".wr_en"}, 64'(rf_wr_en_o), 64'(exp_we));
        chk({tag, ".misaligned"}, 64'(load_misaligned), 64'(exp_mis));
    endtask

    // Loads read 1/2/4 bytes (doubleword falls back to word) from the aligned 32-bit memory word.
    function automatic int ref_bytes(input int size);
        return (size >= 2) ? 4 : (1 << size);
    endfunction

    function automatic bit ref_mis(input int off, input int size);
        return (off % ref_bytes(size)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] data, input int off, input int size,
                                             input bit uns);
        int          nbits;
        logic [63:0] mask, v;
        nbits = 8 * ref_bytes(size);
        mask  = (64'd1 << nbits) - 64'd1;
        v     = ({32'd0, data} >> (8 * (off % 4))) & mask;
        if (!uns && v[nbits-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic start_load(input int off, input int size, input bit uns, input logic [4:0] rd,
                              input bit we);
        in_valid      = 1'b1;
        wb_sel        = 3'b001;
        iadder        = ($urandom & 32'hFFFF_FFF8) | 32'(off);
        load_size     = 2'(size);
        load_unsigned = uns;
        rd_addr       = rd;
        rf_wr_en_i    = we;
        tick();
        in_valid = 1'b0;
    endtask

    logic [31:0] exp_data;
    logic [2:0]  sel;
    logic [4:0]  r_rd;
    bit          r_we, r_uns, r_flush, r_mis, is_load;
    int          r_off, r_size, r_wait;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; alu_src = 1'b0; wb_sel = 3'b000;
        alu_result = '0; imm = '0; iadder = '0; pc_plus_4 = '0; rs2 = '0; rd_addr = '0;
        rf_wr_en_i = 1'b0; load_size = 2'b00; load_unsigned = 1'b0; load_data = '0;
        load_valid = 1'b0;
        #12;
        chk_pulses("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.addr", 64'(rf_rd_addr), 64'd0);
        chk("reset.data", 64'(rf_wr_data), 64'd0);
        chk("reset.ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU operand mux is combinational.
        rs2 = 32'hDEAD_BEEF; imm = 32'h0000_0042; alu_src = 1'b1; #1;
        chk("alu2nd.rs2", 64'(alu_2nd_src), 64'hDEAD_BEEF);
        alu_src = 1'b0; #1;
        chk("alu2nd.imm", 64'(alu_2nd_src), 64'h42);

        // Back-to-back ALU then PC+4.
        in_valid = 1'b1; wb_sel = 3'b000; alu_result = 32'h0000_1234; rd_addr = 5'd5;
        rf_wr_en_i = 1'b1;
        tick();
        chk_pulses("b2b0", 1'b1, 1'b1, 1'b0);
        chk("b2b0.addr", 64'(rf_rd_addr), 64'd5);
        chk("b2b0.data", 64'(rf_wr_data), 64'h1234);
        chk("b2b0.ready", 64'(in_ready), 64'd1);
        wb_sel = 3'b101; pc_plus_4 = 32'h0000_0104; rd_addr = 5'd6;
        tick();
        chk_pulses("b2b1", 1'b1, 1'b1, 1'b0);
        chk("b2b1.addr", 64'(rf_rd_addr), 64'd6);
        chk("b2b1.data", 64'(rf_wr_data), 64'h104);
        chk("b2b1.ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        tick();
        chk_pulses("b2b.idle", 1'b0, 1'b0, 1'b0);
        chk("b2b.hold", 64'(rf_wr_data), 64'h104);

        // Signed byte load, response three cycles after acceptance.
        start_load(3, 0, 1'b0, 5'd7, 1'b1);
        chk("lb.ready0", 64'(in_ready), 64'd0);
        tick();
        chk("lb.ready1", 64'(in_ready), 64'd0);
        tick();
        chk("lb.ready2", 64'(in_ready), 64'd0);
        load_valid = 1'b1; load_data = 32'h80AB_CDEF;
        tick();
        load_valid = 1'b0;
        chk_pulses("lb", 1'b1, 1'b1, 1'b0);
        chk("lb.addr", 64'(rf_rd_addr), 64'd7);
        chk("lb.data", 64'(rf_wr_data), 64'hFFFF_FF80);
        chk("lb.ready", 64'(in_ready), 64'd1);

        // Unsigned half load.
        start_load(2, 1, 1'b1, 5'd8, 1'b1);
        load_valid = 1'b1; load_data = 32'h8001_0000;
        tick();
        load_valid = 1'b0;
        chk_pulses("lhu", 1'b1, 1'b1, 1'b0);
        chk("lhu.data", 64'(rf_wr_data), 64'h0000_8001);

        // Misaligned word load.
        start_load(1, 2, 1'b0, 5'd9, 1'b1);
        load_valid = 1'b1; load_data = 32'h1234_5678;
        tick();
        load_valid = 1'b0;
        chk_pulses("lw.mis", 1'b1, 1'b0, 1'b1);

        // Write to x0 retires without a write.
        in_valid = 1'b1; wb_sel = 3'b000; alu_result = 32'h5555_AAAA; rd_addr = 5'd0;
        rf_wr_en_i = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_pulses("x0", 1'b1, 1'b0, 1'b0);

        // Flush in S_RUN blocks acceptance; stray load_valid in S_RUN is ignored.
        in_valid = 1'b1; flush = 1'b1; rd_addr = 5'd3;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk_pulses("flush.run", 1'b0, 1'b0, 1'b0);
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk_pulses("stray.lv", 1'b0, 1'b0, 1'b0);
        chk("stray.ready", 64'(in_ready), 64'd1);

        // Flush together with the response drops the load.
        start_load(0, 2, 1'b0, 5'd10, 1'b1);
        flush = 1'b1; load_valid = 1'b1; load_data = 32'hCAFE_F00D;
        tick();
        flush = 1'b0; load_valid = 1'b0;
        chk_pulses("flush.wait", 1'b0, 1'b0, 1'b0);
        chk("flush.ready", 64'(in_ready), 64'd1);

        // Asynchronous reset in the middle of a load.
        start_load(0, 2, 1'b0, 5'd11, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_pulses("rst.mid", 1'b0, 1'b0, 1'b0);
        chk("rst.mid.data", 64'(rf_wr_data), 64'd0);
        chk("rst.mid.addr", 64'(rf_rd_addr), 64'd0);
        chk("rst.mid.ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Randomized mix of non-load and load instructions.
        for (int i = 0; i < 200; i++) begin
            is_load    = ($urandom_range(0, 3) == 0);
            r_rd       = 5'($urandom_range(0, 31));
            r_we       = 1'($urandom_range(0, 1));
            alu_result = $urandom; imm = $urandom; pc_plus_4 = $urandom; iadder = $urandom;
            if (!is_load) begin
                sel = 3'($urandom_range(0, 7));
                if (sel == 3'b001) sel = 3'b110;
                if (sel == 3'b010)      exp_data = imm;
                else if (sel == 3'b011) exp_data = iadder;
                else if (sel == 3'b101) exp_data = pc_plus_4;
                else                    exp_data = alu_result;
                in_valid = 1'b1; wb_sel = sel; rd_addr = r_rd; rf_wr_en_i = r_we;
                load_valid = 1'($urandom_range(0, 1));
                tick();
                in_valid = 1'b0; load_valid = 1'b0;
                chk_pulses("rnd.op", 1'b1, r_we && (r_rd != 0), 1'b0);
                chk("rnd.op.addr", 64'(rf_rd_addr), 64'(r_rd));
                chk("rnd.op.data", 64'(rf_wr_data), 64'(exp_data));
                chk("rnd.op.ready", 64'(in_ready), 64'd1);
            end else begin
                r_off   = $urandom_range(0, 7);
                r_size  = $urandom_range(0, 3);
                r_uns   = 1'($urandom_range(0, 1));
                r_wait  = $urandom_range(0, 3);
                r_flush = ($urandom_range(0, 7) == 0);
                start_load(r_off, r_size, r_uns, r_rd, r_we);
                chk("rnd.ld.ready", 64'(in_ready), 64'd0);
                for (int w = 0; w < r_wait; w++) begin
                    tick();
                    chk_pulses("rnd.ld.wait", 1'b0, 1'b0, 1'b0);
                end
                load_valid = 1'b1; load_data = $urandom; flush = r_flush;
                tick();
                load_valid = 1'b0; flush = 1'b0;
                if (r_flush) begin
                    chk_pulses("rnd.ld.flush", 1'b0, 1'b0, 1'b0);
                end else begin
                    r_mis = ref_mis(r_off, r_size);
                    chk_pulses("rnd.ld", 1'b1, r_we && (r_rd != 0) && !r_mis, r_mis);
                    chk("rnd.ld.addr", 64'(rf_rd_addr), 64'(r_rd));
                    if (!r_mis) begin
                        chk("rnd.ld.data", 64'(rf_wr_data),
                            64'(ref_load(load_data, r_off, r_size, r_uns)));
                    end
                end
                chk("rnd.ld.ready.after", 64'(in_ready), 64'd1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
